// File: rtl/select_encode_pkg.sv
// Shared constants for the register-select / encode unit: IR geometry and opcodes.
package select_encode_pkg;

  localparam int unsigned IR_W         = 32;
  localparam int unsigned OPC_W        = 5;
  localparam int unsigned IR_FIELD_MSB = 26;

  localparam logic [OPC_W-1:0] OPC_JAL = 5'b10101;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on load issue, cleared on write-back.
module reg_scoreboard #(
  parameter  int unsigned NUM_REGS = 16,
  localparam int unsigned SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                set,
  input  logic [SEL_W-1:0]    set_sel,
  input  logic                clr,
  input  logic [SEL_W-1:0]    clr_sel,
  output logic [NUM_REGS-1:0] busy_vec
);

  // Set is applied after clear so a same-index collision leaves the bit set.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_vec <= '0;
    end else begin
      if (clr) busy_vec[clr_sel] <= 1'b0;
      if (set) busy_vec[set_sel] <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_select_encode.sv
// Instruction register, Ra/Rb/Rc one-hot select, C sign-extension and load-pending stall.
// Optional scoreboard enabled by defining SELECT_ENCODE_SCOREBOARD_EN.
module reg_select_encode
  import select_encode_pkg::*;
#(
  parameter  int unsigned NUM_REGS = 16,
  parameter  int unsigned LINK_REG = 15,
  localparam int unsigned SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IR_W-1:0]     ir_in,
  input  logic                ir_load,
  input  logic                Gra,
  input  logic                Grb,
  input  logic                Grc,
  input  logic                Rin,
  input  logic                Rout,
  input  logic                BAout,
  input  logic                mark_busy,
  input  logic                wb_valid,
  input  logic [SEL_W-1:0]    wb_sel,
  output logic [IR_W-1:0]     ir_q,
  output logic [OPC_W-1:0]    opcode,
  output logic [IR_W-1:0]     c_sign_extended,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                ba_zero,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam int unsigned C_W = IR_FIELD_MSB + 1 - 2 * SEL_W;
  localparam logic [NUM_REGS-1:0] ONE_HOT_0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [SEL_W-1:0] ra, rb, rc, sel;
  logic             sel_valid;
  logic             read_req;
  logic             busy_sel;
  logic [C_W-1:0]   c_field;

  always_ff @(posedge clock) begin
    if (reset) begin
      ir_q <= '0;
    end else if (ir_load) begin
      ir_q <= ir_in;
    end
  end

  assign opcode  = ir_q[IR_W-1 -: OPC_W];
  assign ra      = ir_q[IR_FIELD_MSB -: SEL_W];
  assign rb      = ir_q[IR_FIELD_MSB - SEL_W -: SEL_W];
  assign rc      = ir_q[IR_FIELD_MSB - 2 * SEL_W -: SEL_W];
  assign c_field = ir_q[C_W-1:0];
  assign c_sign_extended = {{(IR_W - C_W){c_field[C_W-1]}}, c_field};

  assign sel_valid = Gra | Grb | Grc;
  assign sel       = Gra ? ra : (Grb ? rb : rc);
  assign read_req  = Rout | BAout;

`ifdef SELECT_ENCODE_SCOREBOARD_EN
  reg_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .set      (mark_busy & sel_valid),
    .set_sel  (sel),
    .clr      (wb_valid),
    .clr_sel  (wb_sel),
    .busy_vec (busy_vec)
  );
  assign busy_sel = busy_vec[sel];
`else
  logic unused_sb;
  assign unused_sb = ^{mark_busy, wb_valid, wb_sel};
  assign busy_vec  = '0;
  assign busy_sel  = 1'b0;
`endif

  // Strobe decode; everything is held low while reset is asserted.
  always_comb begin
    reg_in  = '0;
    reg_out = '0;
    ba_zero = 1'b0;
    stall   = 1'b0;
    if (!reset) begin
      ba_zero = BAout & sel_valid & (sel == '0);
      stall   = read_req & sel_valid & busy_sel;
      if (Rin && opcode == OPC_JAL) begin
        reg_in = ONE_HOT_0 << SEL_W'(LINK_REG);
      end else if (Rin && sel_valid) begin
        reg_in = ONE_HOT_0 << sel;
      end
      if (read_req && sel_valid && !stall && !ba_zero) begin
        reg_out = ONE_HOT_0 << sel;
      end
    end
  end

endmodule

// File: tb/tb_reg_select_encode.sv
// Scoreboard-style bench for reg_select_encode (16-register DUT plus a 32-register DUT for C width).
module tb_reg_select_encode;

`ifdef SELECT_ENCODE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ir_in;
  logic        ir_load, Gra, Grb, Grc, Rin, Rout, BAout, mark_busy, wb_valid;
  logic [3:0]  wb_sel;

  logic [31:0] ir_q, c_sext;
  logic [4:0]  opcode;
  logic [15:0] reg_in, reg_out, busy_vec;
  logic        ba_zero, stall;

  logic [31:0] ir_q32, c_sext32;
  logic [4:0]  opcode32;
  logic [31:0] reg_in32, reg_out32, busy_vec32;
  logic        ba_zero32, stall32;

  always #5 clock = ~clock;

  reg_select_encode #(.NUM_REGS(16), .LINK_REG(15)) dut (
    .clock(clock), .reset(reset), .ir_in(ir_in), .ir_load(ir_load),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .mark_busy(mark_busy), .wb_valid(wb_valid), .wb_sel(wb_sel),
    .ir_q(ir_q), .opcode(opcode), .c_sign_extended(c_sext),
    .reg_in(reg_in), .reg_out(reg_out), .ba_zero(ba_zero), .stall(stall),
    .busy_vec(busy_vec)
  );

  reg_select_encode #(.NUM_REGS(32), .LINK_REG(31)) dut32 (
    .clock(clock), .reset(reset), .ir_in(ir_in), .ir_load(ir_load),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .mark_busy(mark_busy), .wb_valid(wb_valid), .wb_sel({1'b0, wb_sel}),
    .ir_q(ir_q32), .opcode(opcode32), .c_sign_extended(c_sext32),
    .reg_in(reg_in32), .reg_out(reg_out32), .ba_zero(ba_zero32), .stall(stall32),
    .busy_vec(busy_vec32)
  );

  typedef enum int {S_REG_IN, S_REG_OUT, S_BA_ZERO, S_STALL, S_BUSY,
                    S_IR_Q, S_OPCODE, S_CSEXT, S_CSEXT32} sig_e;
  typedef struct {
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] sample(sig_e s);
    case (s)
      S_REG_IN:  return {16'h0, reg_in};
      S_REG_OUT: return {16'h0, reg_out};
      S_BA_ZERO: return {31'h0, ba_zero};
      S_STALL:   return {31'h0, stall};
      S_BUSY:    return {16'h0, busy_vec};
      S_IR_Q:    return ir_q;
      S_OPCODE:  return {27'h0, opcode};
      S_CSEXT:   return c_sext;
      default:   return c_sext32;
    endcase
  endfunction

  // Monitor: outputs are settled mid-cycle, so drain all pending expectations there.
  initial begin
    exp_t e;
    logic [31:0] got;
    forever begin
      @(negedge clock);
      while (q.size() > 0) begin
        e   = q.pop_front();
        got = sample(e.sig);
        checks++;
        if (got !== e.val) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, got, e.val);
        end
      end
    end
  end

  task automatic exp_push(sig_e s, logic [31:0] v, string n);
    exp_t e;
    e.sig = s; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic idle();
    ir_load = 0; Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
    mark_busy = 0; wb_valid = 0; wb_sel = 4'd0;
  endtask

  task automatic cycle();
    @(negedge clock);
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic load(logic [31:0] v);
    ir_in = v; ir_load = 1;
    cycle();
  endtask

  initial begin
    idle();
    ir_in = 32'h0;
    reset = 1;
    #1;
    Gra = 1; Rin = 1; Rout = 1; BAout = 1; mark_busy = 1;
    exp_push(S_REG_IN,  32'h0, "rst_reg_in");
    exp_push(S_REG_OUT, 32'h0, "rst_reg_out");
    exp_push(S_BA_ZERO, 32'h0, "rst_ba_zero");
    exp_push(S_STALL,   32'h0, "rst_stall");
    cycle();
    reset = 0;
    exp_push(S_IR_Q,   32'h0, "rst_ir_q");
    exp_push(S_OPCODE, 32'h0, "rst_opcode");
    exp_push(S_CSEXT,  32'h0, "rst_csext");
    exp_push(S_BUSY,   32'h0, "rst_busy");
    cycle();

    // Ra=3 Rb=7 Rc=12; same-cycle strobes still see the old (zero) IR
    ir_in = 32'h01BE_0000; ir_load = 1; Gra = 1; Rin = 1;
    exp_push(S_REG_IN, 32'h0001, "old_ir_decode");
    cycle();
    Gra = 1; Rin = 1;
    exp_push(S_REG_IN, 32'h0008, "gra_rin");
    exp_push(S_IR_Q,   32'h01BE_0000, "ir_q_loaded");
    exp_push(S_CSEXT,  32'hFFFE_0000, "csext_overlap");
    cycle();
    Grb = 1; Rout = 1;
    exp_push(S_REG_OUT, 32'h0080, "grb_rout");
    exp_push(S_REG_IN,  32'h0000, "grb_rout_no_in");
    cycle();
    Gra = 1; Grc = 1; Rout = 1;
    exp_push(S_REG_OUT, 32'h0008, "gra_grc_prio");
    cycle();
    Grc = 1; Rin = 1;
    exp_push(S_REG_IN, 32'h1000, "grc_rin");
    cycle();
    Rout = 1;
    exp_push(S_REG_OUT, 32'h0000, "no_sel_rout");
    cycle();

    // C-field sign extension at 19 bits (16 regs) and 17 bits (32 regs)
    load(32'h0004_0000);
    exp_push(S_CSEXT,   32'hFFFC_0000, "c19_neg");
    exp_push(S_CSEXT32, 32'h0000_0000, "c17_zero");
    cycle();
    load(32'h0003_FFFF);
    exp_push(S_CSEXT,   32'h0003_FFFF, "c19_pos");
    exp_push(S_CSEXT32, 32'hFFFF_FFFF, "c17_neg_all");
    cycle();
    load(32'h0001_0000);
    exp_push(S_CSEXT,   32'h0001_0000, "c19_pos_b16");
    exp_push(S_CSEXT32, 32'hFFFF_0000, "c17_neg");
    cycle();

    // JAL, Ra=5, Rb=0
    load(32'hAA80_0000);
    Gra = 1; Rin = 1;
    exp_push(S_OPCODE, 32'h15, "jal_opcode");
    exp_push(S_REG_IN, 32'h8000, "jal_link");
    cycle();
    Rin = 1;
    exp_push(S_REG_IN, 32'h8000, "jal_link_no_g");
    cycle();
    Grb = 1; BAout = 1;
    exp_push(S_REG_OUT, 32'h0000, "ba_r0_out");
    exp_push(S_BA_ZERO, 32'h1, "ba_r0_zero");
    cycle();
    Grb = 1; Rout = 1;
    exp_push(S_REG_OUT, 32'h0001, "rout_r0");
    exp_push(S_BA_ZERO, 32'h0, "rout_r0_no_ba");
    cycle();
    Gra = 1; BAout = 1;
    exp_push(S_REG_OUT, 32'h0020, "ba_r5");
    exp_push(S_BA_ZERO, 32'h0, "ba_r5_no_zero");
    cycle();

    // Scoreboard on R4
    load(32'h0200_0000);
    Gra = 1; Rout = 1; mark_busy = 1;
    exp_push(S_STALL,   32'h0, "mark_cycle_stall");
    exp_push(S_REG_OUT, 32'h0010, "mark_cycle_out");
    cycle();
    Gra = 1; Rout = 1;
    exp_push(S_STALL,   SB ? 32'h1 : 32'h0, "busy_stall");
    exp_push(S_REG_OUT, SB ? 32'h0 : 32'h0010, "busy_out");
    exp_push(S_BUSY,    SB ? 32'h0010 : 32'h0, "busy_r4");
    cycle();
    Gra = 1; Rin = 1;
    exp_push(S_REG_IN, 32'h0010, "rin_busy");
    exp_push(S_STALL,  32'h0, "rin_no_stall");
    cycle();
    Gra = 1; Rout = 1; wb_valid = 1; wb_sel = 4'd4;
    exp_push(S_STALL, SB ? 32'h1 : 32'h0, "wb_cycle_stall");
    exp_push(S_BUSY,  SB ? 32'h0010 : 32'h0, "rin_keeps_busy");
    cycle();
    Gra = 1; Rout = 1;
    exp_push(S_STALL,   32'h0, "released_stall");
    exp_push(S_REG_OUT, 32'h0010, "released_out");
    exp_push(S_BUSY,    32'h0, "released_busy");
    cycle();
    mark_busy = 1;
    cycle();
    exp_push(S_BUSY, 32'h0, "mark_no_sel");
    Gra = 1; mark_busy = 1; wb_valid = 1; wb_sel = 4'd4;
    cycle();
    Gra = 1; BAout = 1;
    exp_push(S_BUSY,    SB ? 32'h0010 : 32'h0, "set_wins");
    exp_push(S_STALL,   SB ? 32'h1 : 32'h0, "ba_busy_stall");
    exp_push(S_REG_OUT, SB ? 32'h0 : 32'h0010, "ba_busy_out");
    cycle();

    // Busy R2 and R9, then reset with strobes active
    load(32'h0148_0000);
    Gra = 1; mark_busy = 1; wb_valid = 1; wb_sel = 4'd4;
    cycle();
    Grb = 1; mark_busy = 1;
    exp_push(S_BUSY, SB ? 32'h0004 : 32'h0, "busy_r2");
    cycle();
    Grb = 1; Rout = 1;
    exp_push(S_BUSY,    SB ? 32'h0204 : 32'h0, "busy_r2_r9");
    exp_push(S_STALL,   SB ? 32'h1 : 32'h0, "stall_r9");
    exp_push(S_REG_OUT, SB ? 32'h0 : 32'h0200, "out_r9");
    cycle();
    reset = 1; Gra = 1; Rin = 1; Rout = 1; BAout = 1; mark_busy = 1;
    exp_push(S_REG_IN,  32'h0, "rst2_reg_in");
    exp_push(S_REG_OUT, 32'h0, "rst2_reg_out");
    exp_push(S_BA_ZERO, 32'h0, "rst2_ba_zero");
    exp_push(S_STALL,   32'h0, "rst2_stall");
    cycle();
    reset = 0; Gra = 1; Rin = 1;
    exp_push(S_BUSY,   32'h0, "rst2_busy");
    exp_push(S_IR_Q,   32'h0, "rst2_ir_q");
    exp_push(S_OPCODE, 32'h0, "rst2_opcode");
    exp_push(S_CSEXT,  32'h0, "rst2_csext");
    exp_push(S_REG_IN, 32'h0001, "rst2_reg_in_r0");
    cycle();

    @(negedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_select_encode.md
# reg_select_encode

Parametrised register-select and encode unit for the datapath control path. Latches the instruction register, decodes the Ra/Rb/Rc fields into one-hot register-file enables for any power-of-two register count, and sign-extends the C constant. Tracks registers with an outstanding load in a pending-write scoreboard and stalls reads of them. Sits between the control sequencer (G*/Rin/Rout/BAout strobes) and the register file / bus multiplexer.

## Interface
Parameters:
- NUM_REGS, 16, register count; power of two, 2..32
- LINK_REG, 15, register written by jump-and-link
- SEL_W, clog2(NUM_REGS), derived localparam, not overridable

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ir_in  in  32  instruction word from bus
- ir_load  in  1  capture ir_in into the IR
- Gra, Grb, Grc  in  1 each  field select strobes
- Rin, Rout, BAout  in  1 each  register write / read / base-address read strobes
- mark_busy  in  1  set scoreboard bit of the selected register (load issued)
- wb_valid  in  1  load write-back complete
- wb_sel  in  SEL_W  register index being written back
- ir_q  out  32  latched IR
- opcode  out  5  ir_q[31:27]
- c_sign_extended  out  32  C field sign-extended
- reg_in  out  NUM_REGS  one-hot write enables
- reg_out  out  NUM_REGS  one-hot read enables
- ba_zero  out  1  BAout on R0: bus must drive zero
- stall  out  1  selected register busy on a read
- busy_vec  out  NUM_REGS  scoreboard state

## Operation
- Fields: Ra = ir_q[26 -: SEL_W], Rb = next SEL_W bits below, Rc = next below that. C field = ir_q[26-2*SEL_W:0], width 27-2*SEL_W (19 at NUM_REGS=16), sign bit at its MSB.
- Select priority Gra > Grb > Grc; none asserted: no selection, reg_in and reg_out all zero.
- reg_in = one-hot(sel) when Rin. Exception: opcode == OPC_JAL and Rin: reg_in = one-hot(LINK_REG) regardless of G strobes.
- reg_out = one-hot(sel) when Rout or BAout, unless stall or ba_zero.
- ba_zero = BAout & selection valid & sel == 0; reg_out all zero then. Rout on R0 reads R0 normally.
- Scoreboard: mark_busy with a valid selection sets busy_vec[sel]; wb_valid clears busy_vec[wb_sel]. Same cycle, same index: set wins. mark_busy without selection: ignored.
- stall = (Rout | BAout) & selection valid & busy_vec[sel]. Rin to a busy register is allowed and does not change busy_vec.

## Timing
- ir_load: ir_q updates at the edge; decode from the new IR valid in the following cycle. ir_load and G strobes in the same cycle decode the old IR.
- reg_in, reg_out, ba_zero, stall: combinational from ir_q, busy_vec and strobes; zero latency.
- busy_vec updates at the edge; a set is seen by stall from the next cycle; a clear releases stall from the next cycle.
- Reset (any time, including mid-load): ir_q = 0, busy_vec = 0 at the edge; while reset is high, reg_in, reg_out, ba_zero and stall are forced to 0. After reset: opcode = 0, c_sign_extended = 0.

## Configuration
- SELECT_ENCODE_SCOREBOARD_EN defined: scoreboard, stall and busy_vec behave as above.
- Not defined: no scoreboard flops; busy_vec tied to 0, stall tied to 0, mark_busy/wb_valid/wb_sel ignored; all other behaviour unchanged.

## Structure
- Package select_encode_pkg: OPC_JAL = 5'b10101, OPC_W = 5, IR_FIELD_MSB = 26, IR width 32.
- Sub-module reg_scoreboard (NUM_REGS; set/set_sel, clr/clr_sel, busy_vec), instantiated only under SELECT_ENCODE_SCOREBOARD_EN.

## Test plan
- NUM_REGS=16, load IR with Ra=3, Rb=7, Rc=12; Gra+Rin -> reg_in = 0x0008; Grb+Rout -> reg_out = 0x0080; Gra+Grc+Rout -> reg_out = 0x0008.
- C field = 0x40000 -> c_sign_extended = 0xFFFC0000; C = 0x3FFFF -> 0x0003FFFF; NUM_REGS=32 build checks 17-bit C at ir_q[16:0].
- IR opcode 10101, Gra=5, Rin -> reg_in = 0x8000; Rb=0 with Grb+BAout -> reg_out = 0, ba_zero = 1; Grb+Rout -> reg_out = 0x0001.
- Gra=4 + mark_busy; next cycle Gra+Rout -> stall = 1, reg_out = 0; wb_valid, wb_sel=4 -> next cycle stall = 0, reg_out = 0x0010; same-cycle set and clear of R4 -> busy_vec[4] = 1.
- Busy R2/R9, then reset for one cycle with strobes active -> outputs 0 during reset, busy_vec = 0, ir_q = 0 after.
- Build without SELECT_ENCODE_SCOREBOARD_EN: mark_busy then Rout on same register -> stall = 0, read proceeds.
